// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants and counter helpers for the video pipeline
package vga_pkg;
  typedef logic [9:0] cnt_t;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  function automatic logic in_win(input cnt_t c, input cnt_t lo, input cnt_t hi);
    return c >= lo && c < hi;
  endfunction
endpackage

// File: rtl/pix_clk_en.sv
// pix_clk_en: divides clk by CLK_DIV into a one-cycle pixel strobe, frozen while en is low
module pix_clk_en #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pix_tick
);
  localparam logic [3:0] LAST = 4'(CLK_DIV - 1);
  logic [3:0] div_cnt;
  logic       tc;
  // tc is kept in step with div_cnt==LAST so the strobe leaves a flop, gated only by en
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt <= '0;
      tc      <= LAST == 4'd0;
    end else if (en) begin
      div_cnt <= tc ? 4'd0 : div_cnt + 4'd1;
      tc      <= tc ? LAST == 4'd0 : div_cnt + 4'd1 == LAST;
    end
  assign pix_tick = en & tc;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster counters with registered sync, blanking and line/frame strobes
module vga_sync_gen import vga_pkg::*; #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       active,
  output logic       hs_vga,
  output logic       vs_vga,
  output logic       line_start,
  output logic       frame_start
);
  localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t HA      = cnt_t'(H_ACTIVE);
  localparam cnt_t VA      = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_B    = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_E    = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_B    = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_E    = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  logic tick, ls_q, fs_q, hs_n, vs_n, act_n;
  cnt_t h_nxt, v_nxt;
  pix_clk_en #(.CLK_DIV(CLK_DIV)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pix_tick (tick)
  );
  assign pix_tick = tick;
  // decode the count about to be loaded so every flag lands together with it
  always_comb begin
    h_nxt = hcnt == H_LAST ? '0 : hcnt + 10'd1;
    v_nxt = hcnt != H_LAST ? vcnt : vcnt == V_LAST ? '0 : vcnt + 10'd1;
    act_n = h_nxt < HA && v_nxt < VA;
    hs_n  = in_win(h_nxt, HS_B, HS_E) ? SYNC_POL : ~SYNC_POL;
    vs_n  = in_win(v_nxt, VS_B, VS_E) ? SYNC_POL : ~SYNC_POL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hcnt   <= '0;
      vcnt   <= '0;
      active <= 1'b1;
      hs_vga <= ~SYNC_POL;
      vs_vga <= ~SYNC_POL;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      ls_q <= tick && h_nxt == '0;
      fs_q <= tick && h_nxt == '0 && v_nxt == '0;
      if (tick) begin
        hcnt   <= h_nxt;
        vcnt   <= v_nxt;
        active <= act_n;
        hs_vga <= hs_n;
        vs_vga <= vs_n;
      end
    end
  assign line_start  = en & ls_q;
  assign frame_start = en & fs_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scaled-down raster with a cycle scoreboard, vector table and corner sequences
module tb_vga_sync_gen;
  localparam int CD = 2;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  typedef logic [25:0] vec_t;
  typedef struct {
    logic en;
    int   n_clk;
    int   exp_h;
    int   exp_v;
  } row_t;

  logic clk = 0, rst_n = 0, en = 0;
  logic pix_tick, active, hs_vga, vs_vga, line_start, frame_start;
  logic [9:0] hcnt, vcnt;
  int n_cmp = 0, n_bad = 0;
  bit chk_on = 0;
  vec_t sb[$];
  int m_div, m_p;
  bit m_ls, m_fs;

  vga_sync_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(pix_tick), .hcnt(hcnt), .vcnt(vcnt),
    .active(active), .hs_vga(hs_vga), .vs_vga(vs_vga),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // reference raster kept as a single linear pixel position
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_div = 0; m_p = 0; m_ls = 0; m_fs = 0;
    end else begin
      m_ls = 0; m_fs = 0;
      if (en) begin
        if (m_div == CD - 1) begin
          m_div = 0;
          m_p = (m_p + 1) % (HT * VT);
          m_ls = (m_p % HT) == 0;
          m_fs = m_p == 0;
        end else m_div++;
      end
    end

  function automatic vec_t exp_vec();
    int h, v;
    logic t, a, hsx, vsx;
    h = m_p % HT;
    v = m_p / HT;
    t = rst_n && en && m_div == CD - 1;
    a = h < HA && v < VA;
    hsx = !(h >= HA + HF && h < HA + HF + HS);
    vsx = !(v >= VA + VF && v < VA + VF + VS);
    return {t, 10'(h), 10'(v), a, hsx, vsx, en && m_ls, en && m_fs};
  endfunction

  function automatic vec_t dut_vec();
    return {pix_tick, hcnt, vcnt, active, hs_vga, vs_vga, line_start, frame_start};
  endfunction

  always @(negedge clk)
    if (chk_on) begin
      vec_t e, g;
      #2 sb.push_back(exp_vec());
      #2 begin
        g = dut_vec();
        e = sb.pop_front();
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t got=%h expected=%h", $time, g, e);
        end
      end
    end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_hv(input int h, input int v, input int budget);
    int k = 0;
    while (!(hcnt == 10'(h) && (v < 0 || vcnt == 10'(v))) && k < budget) begin
      step();
      k++;
    end
    chk($sformatf("wait_h%0d_v%0d", h, v), int'(k < budget), 1);
  endtask

  row_t tbl[6];
  vec_t rst_vec;

  initial begin
    int k, lo_clk, lo_tick, bad_act, first_h, fs_n, fs_at, ls_n, dbl, vs_ticks, first_v, ticks, moved;
    bit prev_ls;
    tbl[0] = '{1'b1, 2, 1, 0};
    tbl[1] = '{1'b1, 48, 0, 1};
    tbl[2] = '{1'b0, 10, 0, 1};
    tbl[3] = '{1'b1, 1, 0, 1};
    tbl[4] = '{1'b1, 1, 1, 1};
    tbl[5] = '{1'b1, 748, 0, 1};
    rst_vec = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    repeat (3) step();
    chk("reset_state", int'(dut_vec()), int'(rst_vec));
    chk("reset_hcnt", int'(hcnt), 0);
    chk_on = 1;
    en = 1;
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      en = tbl[i].en;
      repeat (tbl[i].n_clk) step();
      chk($sformatf("tbl%0d_hcnt", i), int'(hcnt), tbl[i].exp_h);
      chk($sformatf("tbl%0d_vcnt", i), int'(vcnt), tbl[i].exp_v);
    end
    // horizontal sync window over one line
    wait_hv(0, -1, 200);
    lo_clk = 0; lo_tick = 0; bad_act = 0; first_h = -1;
    for (int i = 0; i < HT * CD; i++) begin
      if (!hs_vga) begin
        lo_clk++;
        if (pix_tick) lo_tick++;
        if (active) bad_act++;
        if (first_h < 0) first_h = int'(hcnt);
      end
      step();
    end
    chk("hs_low_ticks", lo_tick, HS);
    chk("hs_low_clks", lo_clk, HS * CD);
    chk("hs_first_h", first_h, HA + HF);
    chk("hs_active_low", bad_act, 0);
    // one full frame between frame_start pulses
    k = 0;
    while (!frame_start && k < 2000) begin step(); k++; end
    chk("wait_frame_start", int'(k < 2000), 1);
    fs_n = 0; fs_at = -1; ls_n = 0; dbl = 0; vs_ticks = 0; first_v = -1; prev_ls = 1;
    for (int i = 1; i <= HT * VT * CD; i++) begin
      step();
      if (frame_start) begin fs_n++; fs_at = i; end
      if (line_start) ls_n++;
      if (line_start && prev_ls) dbl++;
      prev_ls = line_start;
      if (!vs_vga && pix_tick) vs_ticks++;
      if (!vs_vga && first_v < 0) first_v = int'(vcnt);
    end
    chk("frame_pulses", fs_n, 1);
    chk("frame_period", fs_at, HT * VT * CD);
    chk("line_pulses", ls_n, VT);
    chk("line_width", dbl, 0);
    chk("vs_low_ticks", vs_ticks, VS * HT);
    chk("vs_first_v", first_v, VA + VF);
    // enable pause mid-line
    wait_hv(10, -1, 200);
    en = 0;
    ticks = 0; moved = 0;
    repeat (50) begin
      step();
      if (pix_tick) ticks++;
      if (hcnt != 10'd10) moved++;
    end
    chk("en_pause_ticks", ticks, 0);
    chk("en_pause_hold", moved, 0);
    en = 1;
    k = 0;
    while (!pix_tick && k < 8) begin step(); k++; end
    chk("en_resume_delay", k, 1);
    step();
    chk("en_resume_hcnt", int'(hcnt), 11);
    // asynchronous reset between edges
    wait_hv(22, 5, 2000);
    @(posedge clk);
    #2 rst_n = 0;
    #1 chk("async_reset", int'(dut_vec()), int'(rst_vec));
    step();
    step();
    rst_n = 1;
    k = 0;
    while (!pix_tick && k < 8) begin step(); k++; end
    chk("restart_first_tick", k, CD - 1);
    step();
    chk("restart_hcnt", int'(hcnt), 1);
    repeat (4) step();
    chk_on = 0;
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
